// File: rtl/execute_pkg.sv
// Shared definitions for the execute stage: opcode, ALU-control and
// pcselect1 encodings plus small opcode-class helpers.
package execute_pkg;

    localparam int unsigned WORD_W = 16;
    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [3:0] {
        OP_BR   = 4'h0, OP_ADD = 4'h1, OP_LD  = 4'h2, OP_ST  = 4'h3,
        OP_JSR  = 4'h4, OP_AND = 4'h5, OP_LDR = 4'h6, OP_STR = 4'h7,
        OP_RTI  = 4'h8, OP_NOT = 4'h9, OP_LDI = 4'hA, OP_STI = 4'hB,
        OP_JMP  = 4'hC, OP_RES = 4'hD, OP_LEA = 4'hE, OP_TRAP = 4'hF
    } opcode_t;

    typedef enum logic [1:0] {
        ALU_ADD  = 2'b00,
        ALU_AND  = 2'b01,
        ALU_NOT  = 2'b10,
        ALU_ZERO = 2'b11
    } alu_ctl_t;

    typedef enum logic [1:0] {
        PC1_OFF11 = 2'b00,
        PC1_OFF9  = 2'b01,
        PC1_OFF6  = 2'b10,
        PC1_ZERO  = 2'b11
    } pcsel1_t;

    // Opcodes whose aluout is the ALU result rather than the address sum.
    function automatic logic is_alu_op(input opcode_t op);
        return (op == OP_ADD) || (op == OP_AND) || (op == OP_NOT);
    endfunction

    // Opcodes that write a destination register.
    function automatic logic writes_dr(input opcode_t op);
        return (op == OP_ADD) || (op == OP_AND) || (op == OP_NOT) ||
               (op == OP_LD)  || (op == OP_LDR) || (op == OP_LDI) ||
               (op == OP_LEA);
    endfunction

    // Stores read their data register from ir[11:9].
    function automatic logic is_store(input opcode_t op);
        return (op == OP_ST) || (op == OP_STR) || (op == OP_STI);
    endfunction

endpackage

// File: rtl/execute_if.sv
// Bus between decode/writeback-side logic and the execute stage.
// master: drives instruction, operands, bypass selects; reads results.
// slave : the execute stage itself.
interface execute_if;
    import execute_pkg::*;

    logic        enable_execute;
    word_t       ir;
    word_t       npc_in;
    logic [5:0]  e_control;      // {alu_control, pcselect1, pcselect2, op2select}
    logic [1:0]  w_control_in;
    logic        mem_control_in;
    word_t       vsr1;
    word_t       vsr2;
    logic        bypass_alu_1;
    logic        bypass_alu_2;
    logic        bypass_mem_1;
    logic        bypass_mem_2;
    word_t       mem_bypass_val;

    word_t       aluout;
    word_t       pcout;
    logic [1:0]  w_control_out;
    logic        mem_control_out;
    word_t       m_data;
    word_t       ir_exec;
    logic [2:0]  dr;
    logic [2:0]  nzp;
    logic [2:0]  sr1;
    logic [2:0]  sr2;

    modport master (
        output enable_execute, ir, npc_in, e_control, w_control_in,
               mem_control_in, vsr1, vsr2, bypass_alu_1, bypass_alu_2,
               bypass_mem_1, bypass_mem_2, mem_bypass_val,
        input  aluout, pcout, w_control_out, mem_control_out, m_data,
               ir_exec, dr, nzp, sr1, sr2
    );

    modport slave (
        input  enable_execute, ir, npc_in, e_control, w_control_in,
               mem_control_in, vsr1, vsr2, bypass_alu_1, bypass_alu_2,
               bypass_mem_1, bypass_mem_2, mem_bypass_val,
        output aluout, pcout, w_control_out, mem_control_out, m_data,
               ir_exec, dr, nzp, sr1, sr2
    );

endinterface

// File: rtl/execute_alu.sv
// Combinational 16-bit ALU: add / and / not / zero, result mod 2^16.
// Ports: ctl (operation), a, b (operands), y (result).
module execute_alu
    import execute_pkg::*;
(
    input  alu_ctl_t ctl,
    input  word_t    a,
    input  word_t    b,
    output word_t    y
);

    always_comb begin
        y = '0;
        case (ctl)
            ALU_ADD: y = a + b;
            ALU_AND: y = a & b;
            ALU_NOT: y = ~a;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/execute.sv
// Execute pipeline stage: operand bypass muxing, ALU, address adder and the
// one-cycle output registers.
// Ports: clock, reset (sync, active-high), bus (execute_if.slave) carrying
// instruction/operands/bypass selects in and registered results out;
// sr1/sr2 on the bus are combinational decodes of the incoming ir.
module execute
    import execute_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    execute_if.slave   bus
);

    opcode_t  op;
    alu_ctl_t alu_ctl;
    pcsel1_t  pcsel1;
    logic     pcselect2;
    logic     op2select;

    word_t    bv1;
    word_t    bv2;
    word_t    op2;
    word_t    alu_res;
    word_t    offset;
    word_t    base;
    word_t    addr;

    assign op        = opcode_t'(bus.ir[15:12]);
    assign alu_ctl   = alu_ctl_t'(bus.e_control[5:4]);
    assign pcsel1    = pcsel1_t'(bus.e_control[3:2]);
    assign pcselect2 = bus.e_control[1];
    assign op2select = bus.e_control[0];

    assign bus.sr1 = bus.ir[8:6];
    assign bus.sr2 = is_store(op) ? bus.ir[11:9] : bus.ir[2:0];

    // ALU forwarding wins over memory forwarding; it reads the registered
    // aluout, which also holds during a stall.
    assign bv1 = bus.bypass_alu_1 ? bus.aluout :
                 bus.bypass_mem_1 ? bus.mem_bypass_val : bus.vsr1;
    assign bv2 = bus.bypass_alu_2 ? bus.aluout :
                 bus.bypass_mem_2 ? bus.mem_bypass_val : bus.vsr2;

    assign op2 = op2select ? bv2 : {{11{bus.ir[4]}}, bus.ir[4:0]};

    always_comb begin
        offset = '0;
        case (pcsel1)
            PC1_OFF11: offset = {{5{bus.ir[10]}}, bus.ir[10:0]};
            PC1_OFF9:  offset = {{7{bus.ir[8]}},  bus.ir[8:0]};
            PC1_OFF6:  offset = {{10{bus.ir[5]}}, bus.ir[5:0]};
            default:   offset = '0;
        endcase
    end

    assign base = pcselect2 ? bus.npc_in : bv1;
    assign addr = base + offset;

    execute_alu u_alu (
        .ctl (alu_ctl),
        .a   (bv1),
        .b   (op2),
        .y   (alu_res)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            bus.aluout          <= '0;
            bus.pcout           <= '0;
            bus.w_control_out   <= '0;
            bus.mem_control_out <= 1'b0;
            bus.m_data          <= '0;
            bus.ir_exec         <= '0;
            bus.dr              <= '0;
            bus.nzp             <= '0;
        end else if (bus.enable_execute) begin
            bus.aluout          <= is_alu_op(op) ? alu_res : addr;
            bus.pcout           <= addr;
            bus.w_control_out   <= bus.w_control_in;
            bus.mem_control_out <= bus.mem_control_in;
            bus.m_data          <= bv2;
            bus.ir_exec         <= bus.ir;
            bus.dr              <= writes_dr(op) ? bus.ir[11:9] : 3'd0;
            if (op == OP_BR)
                bus.nzp <= bus.ir[11:9];
            else if (op == OP_JMP)
                bus.nzp <= 3'b111;
            else
                bus.nzp <= 3'b000;
        end
    end

endmodule

// File: tb/tb_execute.sv
// Self-checking bench for the execute stage: a table of hand-computed
// vectors run through a scoreboard queue, followed by stall, stalled-bypass
// and reset sequences.
module tb_execute;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    execute_if bus();

    execute dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [15:0] ir, npc, vsr1, vsr2, mbv;
        logic [5:0]  ec;
        logic        ba1, ba2, bm1, bm2;
        logic [1:0]  wc;
        logic        mc;
        logic [15:0] e_alu, e_pc, e_md;
        logic [2:0]  e_dr, e_nzp, e_sr1, e_sr2;
    } vec_t;

    typedef struct {
        logic [15:0] alu, pc, md, ir;
        logic [2:0]  dr, nzp;
        logic [1:0]  wc;
        logic        mc;
    } exp_t;

    int    tests = 0;
    int    fails = 0;
    exp_t  sb[$];
    exp_t  last;
    vec_t  vecs[12];
    vec_t  v;
    exp_t  zero_e;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, want);
        end
    endtask

    function automatic exp_t mk_exp(input vec_t x);
        exp_t e;
        e.alu = x.e_alu; e.pc = x.e_pc; e.md = x.e_md; e.ir = x.ir;
        e.dr = x.e_dr; e.nzp = x.e_nzp; e.wc = x.wc; e.mc = x.mc;
        return e;
    endfunction

    // Drive one cycle of inputs, check the combinational decodes, queue the
    // expected registered outputs and compare them after the edge.
    task automatic step(input string tag, input vec_t x, input logic en,
                        input logic rst, input exp_t e);
        exp_t got;
        @(negedge clock);
        bus.ir = x.ir; bus.npc_in = x.npc; bus.vsr1 = x.vsr1; bus.vsr2 = x.vsr2;
        bus.mem_bypass_val = x.mbv; bus.e_control = x.ec;
        bus.bypass_alu_1 = x.ba1; bus.bypass_alu_2 = x.ba2;
        bus.bypass_mem_1 = x.bm1; bus.bypass_mem_2 = x.bm2;
        bus.w_control_in = x.wc; bus.mem_control_in = x.mc;
        bus.enable_execute = en; reset = rst;
        #1;
        chk({tag, " sr1"}, {13'd0, bus.sr1}, {13'd0, x.e_sr1});
        chk({tag, " sr2"}, {13'd0, bus.sr2}, {13'd0, x.e_sr2});
        sb.push_back(e);
        @(posedge clock);
        #1;
        if (sb.size() == 0) begin
            tests++; fails++;
            $display("FAIL %s scoreboard: got empty expected entry", tag);
        end else begin
            got = sb.pop_front();
            chk({tag, " aluout"}, bus.aluout, got.alu);
            chk({tag, " pcout"},  bus.pcout,  got.pc);
            chk({tag, " m_data"}, bus.m_data, got.md);
            chk({tag, " ir_exec"}, bus.ir_exec, got.ir);
            chk({tag, " dr"},  {13'd0, bus.dr},  {13'd0, got.dr});
            chk({tag, " nzp"}, {13'd0, bus.nzp}, {13'd0, got.nzp});
            chk({tag, " w_control_out"}, {14'd0, bus.w_control_out}, {14'd0, got.wc});
            chk({tag, " mem_control_out"}, {15'd0, bus.mem_control_out}, {15'd0, got.mc});
        end
    endtask

    initial begin
        //            ir       npc      vsr1     vsr2     mbv      ec         ba1 ba2 bm1 bm2 wc    mc   alu      pc       m_data   dr  nzp sr1 sr2
        vecs[0]  = '{16'h1263,16'h0000,16'h0005,16'h0000,16'h0000,6'b000000,1'b0,1'b0,1'b0,1'b0,2'b01,1'b0,16'h0008,16'h0268,16'h0000,3'd1,3'd0,3'd1,3'd3};
        vecs[1]  = '{16'h0E05,16'h3001,16'h1111,16'h2222,16'h0000,6'b000110,1'b0,1'b0,1'b0,1'b0,2'b10,1'b1,16'h3006,16'h3006,16'h2222,3'd0,3'd7,3'd0,3'd5};
        vecs[2]  = '{16'h1401,16'h0000,16'h00E0,16'h0010,16'h0000,6'b000001,1'b0,1'b0,1'b0,1'b0,2'b11,1'b0,16'h00F0,16'hFCE1,16'h0010,3'd2,3'd0,3'd0,3'd1};
        vecs[3]  = '{16'h5042,16'h0000,16'h1234,16'h0FFF,16'h0000,6'b010001,1'b1,1'b0,1'b0,1'b0,2'b00,1'b0,16'h00F0,16'h0132,16'h0FFF,3'd0,3'd0,3'd1,3'd2};
        vecs[4]  = '{16'h973F,16'h0000,16'hFFFF,16'h0000,16'h5A5A,6'b101001,1'b0,1'b1,1'b1,1'b1,2'b01,1'b1,16'hA5A5,16'h5A59,16'h00F0,3'd3,3'd0,3'd4,3'd7};
        vecs[5]  = '{16'h3BF0,16'h2000,16'h0001,16'hBEEF,16'h0000,6'b000111,1'b0,1'b0,1'b0,1'b0,2'b00,1'b1,16'h1FF0,16'h1FF0,16'hBEEF,3'd0,3'd0,3'd7,3'd5};
        vecs[6]  = '{16'hC080,16'h0000,16'h4000,16'h0007,16'h0000,6'b111100,1'b0,1'b0,1'b0,1'b0,2'b10,1'b0,16'h4000,16'h4000,16'h0007,3'd0,3'd7,3'd2,3'd0};
        vecs[7]  = '{16'h6CC5,16'h0000,16'h1000,16'h0042,16'h0000,6'b001000,1'b0,1'b0,1'b0,1'b0,2'b01,1'b0,16'h1005,16'h1005,16'h0042,3'd6,3'd0,3'd3,3'd5};
        vecs[8]  = '{16'h1261,16'h0000,16'hFFFF,16'h0003,16'h0000,6'b000000,1'b0,1'b0,1'b0,1'b0,2'b11,1'b1,16'h0000,16'h0260,16'h0003,3'd1,3'd0,3'd1,3'd1};
        vecs[9]  = '{16'h5A85,16'h0000,16'h0100,16'h7777,16'h0000,6'b110001,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,16'h0000,16'h0385,16'h7777,3'd5,3'd0,3'd2,3'd5};
        vecs[10] = '{16'hB9FF,16'h0001,16'h0000,16'h1357,16'h0000,6'b000110,1'b0,1'b0,1'b0,1'b0,2'b01,1'b1,16'h0000,16'h0000,16'h1357,3'd0,3'd0,3'd7,3'd4};
        vecs[11] = '{16'hEE03,16'h3000,16'h0000,16'h0009,16'h0000,6'b000110,1'b0,1'b0,1'b0,1'b0,2'b10,1'b1,16'h3003,16'h3003,16'h0009,3'd7,3'd0,3'd0,3'd3};

        zero_e = '{16'h0, 16'h0, 16'h0, 16'h0, 3'd0, 3'd0, 2'd0, 1'b0};

        // Reset state, held for two edges.
        step("reset0", vecs[0], 1'b1, 1'b1, zero_e);
        step("reset1", vecs[1], 1'b0, 1'b1, zero_e);

        // Table: each row enabled for one cycle, results one cycle later.
        for (int i = 0; i < 12; i++) begin
            step($sformatf("vec%0d", i), vecs[i], 1'b1, 1'b0, mk_exp(vecs[i]));
            last = mk_exp(vecs[i]);
        end

        // Stall: inputs change, registered outputs hold, decodes track ir.
        // An ALU bypass is requested throughout so the resume cycle must
        // pick up the held aluout (3003).
        for (int k = 0; k < 3; k++) begin
            v = vecs[(k == 0) ? 0 : (k == 1) ? 6 : 5];
            v.ba1 = 1'b1;
            step($sformatf("stall%0d", k), v, 1'b0, 1'b0, last);
        end
        v = '{16'h1021,16'h0000,16'h5555,16'h0A0A,16'h0000,6'b000000,1'b1,1'b0,1'b0,1'b0,2'b00,1'b0,16'h3004,16'h3024,16'h0A0A,3'd0,3'd0,3'd0,3'd1};
        step("resume_bypass", v, 1'b1, 1'b0, mk_exp(v));
        last = mk_exp(v);

        // Reset during a stall overrides the hold.
        step("stall_hold", vecs[3], 1'b0, 1'b0, last);
        step("reset_stalled", vecs[3], 1'b0, 1'b1, zero_e);

        // Load something, then reset with valid enabled inputs.
        step("reload", vecs[1], 1'b1, 1'b0, mk_exp(vecs[1]));
        step("reset_enabled", vecs[2], 1'b1, 1'b1, zero_e);

        // First enabled edge after reset works immediately.
        step("post_reset", vecs[0], 1'b1, 1'b0, mk_exp(vecs[0]));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
